nx_node_control_fanout: RTL and testbench
=========================================

Name: nx_node_control_fanout

Overview:
Parametrised successor node controller. Handles the node's I/O mapping table, input signal-state capture, core trigger generation and outbound signal-state messages. Each output has FANOUT programmable destination slots, each with its own enable bit. Changed outputs are serviced by round-robin instead of fixed priority. Sits between the node's inbound message decoder/outbound arbiter and the node core.

Parameters:
STREAM_WIDTH, 32, outbound message width
ADDR_ROW_WIDTH, 4, node row address width
ADDR_COL_WIDTH, 4, node column address width
COMMAND_WIDTH, 2, command field width
INPUTS, 8, core input count (power of two, >=2)
OUTPUTS, 8, core output count (power of two, >=2)
FANOUT, 4, destination slots per output (power of two, >=2)
MAX_IO, max(INPUTS,OUTPUTS), mapping index range

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
node_row_i  in  ADDR_ROW_WIDTH  own row
node_col_i  in  ADDR_COL_WIDTH  own column
trigger_i  in  1  external step trigger
msg_data_o  out  STREAM_WIDTH  outbound message
msg_dir_o  out  2  outbound direction (N=0, E=1, S=2, W=3)
msg_valid_o  out  1  message valid
msg_ready_i  in  1  message accepted
map_io_i  in  clog2(MAX_IO)  I/O index to map
map_input_i  in  1  1=input map, 0=output map
map_remote_row_i  in  ADDR_ROW_WIDTH  remote row
map_remote_col_i  in  ADDR_COL_WIDTH  remote column
map_remote_idx_i  in  clog2(OUTPUTS)  remote I/O index (inputs only)
map_slot_i  in  clog2(FANOUT)  output destination slot
map_enable_i  in  1  output slot enable
map_broadcast_i  in  1  output slot is broadcast
map_seq_i  in  1  input is sequential
map_valid_i  in  1  mapping write strobe
signal_remote_row_i  in  ADDR_ROW_WIDTH  update source row
signal_remote_col_i  in  ADDR_COL_WIDTH  update source column
signal_remote_idx_i  in  clog2(OUTPUTS)  update source index
signal_state_i  in  1  update value
signal_valid_i  in  1  update strobe
core_trigger_o  out  1  core execute pulse
core_inputs_o  out  INPUTS  current input state
core_outputs_i  in  OUTPUTS  core output state
idle_o  out  1  output engine idle, no pending change

Behaviour:
- Clocking and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: all maps, slot enables, input_curr/next/seq, output_last, round-robin pointer = 0. msg_valid_o=0, msg_data_o=0, msg_dir_o=0, core_trigger_o=0, core_inputs_o=0, idle_o=1. Reset mid-send drops the message with no further valid.
- Mapping: a write on map_valid_i takes effect from the next cycle. Output writes set slot {enable, bc, row, col}.
- Inputs:
  - key = {row, col, idx}; every input whose map matches is updated.
  - next is always written.
  - Non-seq inputs also write curr.
  - trigger_i copies next to curr for all inputs.
  - Same cycle, same bit: a non-seq signal update overrides the trigger copy. A seq bit takes the old next into curr and the new value into next.
- core_trigger_o: one-cycle pulse, registered (cycle after cause). It is the OR of all curr bits that changed in that cycle, so a later no-change match never clears an earlier change.
- Output FSM states IDLE, SEND, BCAST:
  - IDLE: if any core_outputs_i != output_last, pick the first changed index at or after rr_ptr, wrapping. Snapshot the value, set output_last for that bit, set rr_ptr = idx+1 (mod OUTPUTS), slot=0, go to SEND.
  - SEND, one cycle per slot:
    - Disabled slot, or non-bc slot targeting own node: skipped.
    - Otherwise drive message {bc, row, col, CMD_SIG_STATE, node_row, node_col, idx, snapshot, zero pad}. Pad width = STREAM_WIDTH - (2*(ROW+COL) + 2 + COMMAND_WIDTH + clog2(OUTPUTS)).
    - Routing: row first (less→N, greater→S), then column (less→W, greater→E).
    - Broadcast goes to BCAST.
    - Advance the slot on accept; after slot FANOUT-1 go to IDLE.
  - BCAST: present the same data to N, E, S, W in order, one accept each, then return to SEND for the next slot.
- Handshake: data and direction are stable while valid && !ready. Valid may deassert only after ready. One message per accept. A new message may be presented the cycle after an accept.
- An output that toggles again mid-send is re-detected after return to IDLE.
- idle_o = (state==IDLE) && no output differs from output_last.

Optional Feature:
NX_NODE_LOOPBACK_EN
- Defined: a non-bc enabled slot targeting own node is applied internally as a signal update (key {node_row, node_col, idx}, snapshot value) in its SEND cycle. If signal_valid_i is high that cycle, the external update has priority and the loopback retries the next cycle. No message is emitted.
- Undefined: such slots are skipped.

Test Plan:
- Reset: after reset, outputs are zero and idle_o=1. Map output 2 slot 0 to (1,3), node=(1,1), toggle core_outputs_i[2] to 1 → one message with msg_dir_o=1 (E), idx=2, state=1.
- Broadcast: slot 1 bc=1, ready held low 3 cycles → data stable; 4 accepts with directions 0,1,2,3, then idle_o=1.
- Round-robin: outputs 0 and 5 change together, rr_ptr=3 → idx 5 is sent first, then idx 0.
- Inputs: input 4 seq, input 1 non-seq, both mapped to (2,2,1); update value 1 → core_inputs_o[1]=1 with trigger pulse, bit 4 stays 0; trigger_i → bit 4=1 with a pulse.
- Same-cycle collision: trigger_i and a non-seq update on the same bit in one cycle → update value wins, a single pulse.
- Loopback (NX_NODE_LOOPBACK_EN): slot targets own node with input 0 mapped to own output 3; toggle output 3 → core_inputs_o[0] follows, no msg_valid_o.

Source files
------------

// File: rtl/nx_node_control_fanout.sv
// nx_node_control_fanout: node I/O mapping, input state capture, core trigger
// generation and round-robin outbound signal-state messages with FANOUT
// destination slots per output.
// Optional build macro NX_NODE_LOOPBACK_EN: enabled non-broadcast slots that
// target this node are applied internally as signal updates instead of skipped.
module nx_node_control_fanout #(
   parameter int STREAM_WIDTH   = 32,
   parameter int ADDR_ROW_WIDTH = 4,
   parameter int ADDR_COL_WIDTH = 4,
   parameter int COMMAND_WIDTH  = 2,
   parameter int INPUTS         = 8,
   parameter int OUTPUTS        = 8,
   parameter int FANOUT         = 4,
   parameter int MAX_IO         = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [ADDR_ROW_WIDTH-1:0]     node_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]     node_col_i,
   input  logic                          trigger_i,
   output logic [STREAM_WIDTH-1:0]       msg_data_o,
   output logic [1:0]                    msg_dir_o,
   output logic                          msg_valid_o,
   input  logic                          msg_ready_i,
   input  logic [$clog2(MAX_IO)-1:0]     map_io_i,
   input  logic                          map_input_i,
   input  logic [ADDR_ROW_WIDTH-1:0]     map_remote_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]     map_remote_col_i,
   input  logic [$clog2(OUTPUTS)-1:0]    map_remote_idx_i,
   input  logic [$clog2(FANOUT)-1:0]     map_slot_i,
   input  logic                          map_enable_i,
   input  logic                          map_broadcast_i,
   input  logic                          map_seq_i,
   input  logic                          map_valid_i,
   input  logic [ADDR_ROW_WIDTH-1:0]     signal_remote_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]     signal_remote_col_i,
   input  logic [$clog2(OUTPUTS)-1:0]    signal_remote_idx_i,
   input  logic                          signal_state_i,
   input  logic                          signal_valid_i,
   output logic                          core_trigger_o,
   output logic [INPUTS-1:0]             core_inputs_o,
   input  logic [OUTPUTS-1:0]            core_outputs_i,
   output logic                          idle_o
);

   localparam int RW     = ADDR_ROW_WIDTH;
   localparam int CW     = ADDR_COL_WIDTH;
   localparam int IO_W   = $clog2(MAX_IO);
   localparam int OI_W   = $clog2(OUTPUTS);
   localparam int SL_W   = $clog2(FANOUT);
   localparam int BODY_W = 2*(RW+CW) + 2 + COMMAND_WIDTH + OI_W;
   localparam int PAD_W  = STREAM_WIDTH - BODY_W;
   localparam logic [COMMAND_WIDTH-1:0] CMD_SIG_STATE = COMMAND_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_BCAST} state_t;

   // mapping tables
   logic [INPUTS-1:0][RW-1:0]               in_row_q, in_row_d;
   logic [INPUTS-1:0][CW-1:0]               in_col_q, in_col_d;
   logic [INPUTS-1:0][OI_W-1:0]             in_idx_q, in_idx_d;
   logic [INPUTS-1:0]                       in_seq_q, in_seq_d;
   logic [OUTPUTS-1:0][FANOUT-1:0]          out_en_q, out_en_d;
   logic [OUTPUTS-1:0][FANOUT-1:0]          out_bc_q, out_bc_d;
   logic [OUTPUTS-1:0][FANOUT-1:0][RW-1:0]  out_row_q, out_row_d;
   logic [OUTPUTS-1:0][FANOUT-1:0][CW-1:0]  out_col_q, out_col_d;

   // input state
   logic [INPUTS-1:0] curr_q, curr_d, next_q, next_d;
   logic              trig_q, trig_d;

   // output engine
   state_t                  state_q, state_d;
   logic [OI_W-1:0]         rr_q, rr_d, idx_q, idx_d, sel;
   logic [SL_W-1:0]         slot_q, slot_d;
   logic                    snap_q, snap_d;
   logic [OUTPUTS-1:0]      out_last_q, out_last_d, changed;
   logic                    msg_valid_q, msg_valid_d;
   logic [STREAM_WIDTH-1:0] msg_data_q, msg_data_d, msg_word;
   logic [1:0]              msg_dir_q, msg_dir_d, cur_dir;
   logic                    found, adv, lb_fire;

   // internal/external update mux
   logic            upd_valid, upd_state;
   logic [RW-1:0]   upd_row;
   logic [CW-1:0]   upd_col;
   logic [OI_W-1:0] upd_idx;

   // current slot of the output being serviced
   logic          cur_en, cur_bc, cur_own;
   logic [RW-1:0] cur_row;
   logic [CW-1:0] cur_col;

   assign cur_en  = out_en_q[idx_q][slot_q];
   assign cur_bc  = out_bc_q[idx_q][slot_q];
   assign cur_row = out_row_q[idx_q][slot_q];
   assign cur_col = out_col_q[idx_q][slot_q];
   assign cur_own = (cur_row == node_row_i) && (cur_col == node_col_i);
   // row first (N/S), then column (W/E)
   assign cur_dir = (cur_row < node_row_i) ? 2'd0 :
                    (cur_row > node_row_i) ? 2'd2 :
                    (cur_col < node_col_i) ? 2'd3 : 2'd1;
   assign msg_word = STREAM_WIDTH'({cur_bc, cur_row, cur_col, CMD_SIG_STATE,
                                    node_row_i, node_col_i, idx_q, snap_q}) << PAD_W;

   assign changed        = core_outputs_i ^ out_last_q;
   assign idle_o         = (state_q == S_IDLE) && !(|changed);
   assign msg_valid_o    = msg_valid_q;
   assign msg_data_o     = msg_data_q;
   assign msg_dir_o      = msg_dir_q;
   assign core_trigger_o = trig_q;
   assign core_inputs_o  = curr_q;

   assign upd_valid = signal_valid_i | lb_fire;
   assign upd_row   = lb_fire ? node_row_i : signal_remote_row_i;
   assign upd_col   = lb_fire ? node_col_i : signal_remote_col_i;
   assign upd_idx   = lb_fire ? idx_q      : signal_remote_idx_i;
   assign upd_state = lb_fire ? snap_q     : signal_state_i;

   // mapping table writes
   always_comb begin
      in_row_d  = in_row_q;
      in_col_d  = in_col_q;
      in_idx_d  = in_idx_q;
      in_seq_d  = in_seq_q;
      out_en_d  = out_en_q;
      out_bc_d  = out_bc_q;
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      if (map_valid_i) begin
         if (map_input_i) begin
            for (int i = 0; i < INPUTS; i++) begin
               if (map_io_i == IO_W'(i)) begin
                  in_row_d[i] = map_remote_row_i;
                  in_col_d[i] = map_remote_col_i;
                  in_idx_d[i] = map_remote_idx_i;
                  in_seq_d[i] = map_seq_i;
               end
            end
         end else begin
            for (int o = 0; o < OUTPUTS; o++) begin
               if (map_io_i == IO_W'(o)) begin
                  out_en_d[o][map_slot_i]  = map_enable_i;
                  out_bc_d[o][map_slot_i]  = map_broadcast_i;
                  out_row_d[o][map_slot_i] = map_remote_row_i;
                  out_col_d[o][map_slot_i] = map_remote_col_i;
               end
            end
         end
      end
   end

   // input capture: trigger copy first, matching updates override it
   always_comb begin
      curr_d = trigger_i ? next_q : curr_q;
      next_d = next_q;
      if (upd_valid) begin
         for (int i = 0; i < INPUTS; i++) begin
            if ((in_row_q[i] == upd_row) && (in_col_q[i] == upd_col) &&
                (in_idx_q[i] == upd_idx)) begin
               next_d[i] = upd_state;
               if (!in_seq_q[i]) curr_d[i] = upd_state;
            end
         end
      end
      trig_d = |(curr_d ^ curr_q);
   end

   // output engine next-state and message registers
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      idx_d       = idx_q;
      slot_d      = slot_q;
      snap_d      = snap_q;
      out_last_d  = out_last_q;
      msg_valid_d = msg_valid_q;
      msg_data_d  = msg_data_q;
      msg_dir_d   = msg_dir_q;
      found       = 1'b0;
      sel         = '0;
      adv         = 1'b0;
      lb_fire     = 1'b0;
      case (state_q)
         S_IDLE: begin
            for (int k = 0; k < OUTPUTS; k++) begin
               if (!found && changed[rr_q + OI_W'(k)]) begin
                  found = 1'b1;
                  sel   = rr_q + OI_W'(k);
               end
            end
            if (found) begin
               snap_d          = core_outputs_i[sel];
               out_last_d[sel] = core_outputs_i[sel];
               rr_d            = sel + OI_W'(1);
               idx_d           = sel;
               slot_d          = '0;
               state_d         = S_SEND;
            end
         end
         S_SEND: begin
            if (msg_valid_q) begin
               if (msg_ready_i) begin
                  msg_valid_d = 1'b0;
                  adv         = 1'b1;
               end
            end else if (!cur_en) begin
               adv = 1'b1;
            end else if (cur_bc) begin
               msg_data_d  = msg_word;
               msg_dir_d   = 2'd0;
               msg_valid_d = 1'b1;
               state_d     = S_BCAST;
            end else if (cur_own) begin
`ifdef NX_NODE_LOOPBACK_EN
               // external update wins this cycle; retry next cycle
               if (!signal_valid_i) begin
                  lb_fire = 1'b1;
                  adv     = 1'b1;
               end
`else
               adv = 1'b1;
`endif
            end else begin
               msg_data_d  = msg_word;
               msg_dir_d   = cur_dir;
               msg_valid_d = 1'b1;
            end
         end
         S_BCAST: begin
            if (msg_ready_i) begin
               if (msg_dir_q == 2'd3) begin
                  msg_valid_d = 1'b0;
                  adv         = 1'b1;
               end else begin
                  msg_dir_d = msg_dir_q + 2'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (adv) begin
         if (slot_q == SL_W'(FANOUT-1)) begin
            state_d = S_IDLE;
         end else begin
            slot_d  = slot_q + SL_W'(1);
            state_d = S_SEND;
         end
      end
   end

   // state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         in_row_q    <= '0;
         in_col_q    <= '0;
         in_idx_q    <= '0;
         in_seq_q    <= '0;
         out_en_q    <= '0;
         out_bc_q    <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         curr_q      <= '0;
         next_q      <= '0;
         trig_q      <= 1'b0;
         state_q     <= S_IDLE;
         rr_q        <= '0;
         idx_q       <= '0;
         slot_q      <= '0;
         snap_q      <= 1'b0;
         out_last_q  <= '0;
         msg_valid_q <= 1'b0;
         msg_data_q  <= '0;
         msg_dir_q   <= '0;
      end else begin
         in_row_q    <= in_row_d;
         in_col_q    <= in_col_d;
         in_idx_q    <= in_idx_d;
         in_seq_q    <= in_seq_d;
         out_en_q    <= out_en_d;
         out_bc_q    <= out_bc_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         curr_q      <= curr_d;
         next_q      <= next_d;
         trig_q      <= trig_d;
         state_q     <= state_d;
         rr_q        <= rr_d;
         idx_q       <= idx_d;
         slot_q      <= slot_d;
         snap_q      <= snap_d;
         out_last_q  <= out_last_d;
         msg_valid_q <= msg_valid_d;
         msg_data_q  <= msg_data_d;
         msg_dir_q   <= msg_dir_d;
      end
   end

endmodule

// File: tb/tb_nx_node_control_fanout.sv
// Scoreboard bench for nx_node_control_fanout: stimulus pushes expected
// messages / trigger-pulse input states, monitors pop and compare.
module tb_nx_node_control_fanout;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, trigger_i, msg_valid_o, msg_ready_i;
   logic [3:0]  node_row_i, node_col_i;
   logic [31:0] msg_data_o;
   logic [1:0]  msg_dir_o;
   logic [2:0]  map_io_i, map_remote_idx_i, signal_remote_idx_i;
   logic [1:0]  map_slot_i;
   logic        map_input_i, map_enable_i, map_broadcast_i, map_seq_i, map_valid_i;
   logic [3:0]  map_remote_row_i, map_remote_col_i, signal_remote_row_i, signal_remote_col_i;
   logic        signal_state_i, signal_valid_i, core_trigger_o, idle_o;
   logic [7:0]  core_inputs_o, core_outputs_i;

   nx_node_control_fanout dut (
      .clk_i(clk), .rst_i(rst_i), .node_row_i(node_row_i), .node_col_i(node_col_i),
      .trigger_i(trigger_i), .msg_data_o(msg_data_o), .msg_dir_o(msg_dir_o),
      .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i), .map_io_i(map_io_i),
      .map_input_i(map_input_i), .map_remote_row_i(map_remote_row_i),
      .map_remote_col_i(map_remote_col_i), .map_remote_idx_i(map_remote_idx_i),
      .map_slot_i(map_slot_i), .map_enable_i(map_enable_i),
      .map_broadcast_i(map_broadcast_i), .map_seq_i(map_seq_i), .map_valid_i(map_valid_i),
      .signal_remote_row_i(signal_remote_row_i), .signal_remote_col_i(signal_remote_col_i),
      .signal_remote_idx_i(signal_remote_idx_i), .signal_state_i(signal_state_i),
      .signal_valid_i(signal_valid_i), .core_trigger_o(core_trigger_o),
      .core_inputs_o(core_inputs_o), .core_outputs_i(core_outputs_i), .idle_o(idle_o)
   );

   typedef struct packed {
      logic [1:0]  dir;
      logic [31:0] data;
   } msg_t;

   msg_t       msg_exp[$];
   logic [7:0] trig_exp[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   // node is (1,1); command code 1; 9 pad bits
   function automatic logic [31:0] mk(input logic bc, input logic [3:0] r, input logic [3:0] c,
                                      input logic [2:0] idx, input logic st);
      mk = {bc, r, c, 2'd1, 4'd1, 4'd1, idx, st, 9'd0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_msg(input logic [1:0] d, input logic [31:0] m);
      msg_t e;
      e.dir  = d;
      e.data = m;
      msg_exp.push_back(e);
   endtask

   // message monitor with handshake stability check
   logic        pv = 1'b0, pr = 1'b0;
   logic [31:0] pd;
   logic [1:0]  pdir;
   always @(negedge clk) begin
      if (!rst_i) begin
         if (pv && !pr) begin
            chk("hold_valid", {63'd0, msg_valid_o}, 64'd1);
            chk("hold_data", {30'd0, msg_dir_o, msg_data_o}, {30'd0, pdir, pd});
         end
         if (msg_valid_o && msg_ready_i) begin
            if (msg_exp.size() == 0) begin
               chk("unexpected_msg", {30'd0, msg_dir_o, msg_data_o}, 64'd0);
            end else begin
               msg_t e;
               e = msg_exp.pop_front();
               chk("msg", {30'd0, msg_dir_o, msg_data_o}, {30'd0, e.dir, e.data});
            end
         end
      end
      pv   = msg_valid_o && !rst_i;
      pr   = msg_ready_i;
      pd   = msg_data_o;
      pdir = msg_dir_o;
   end

   // trigger-pulse monitor
   always @(negedge clk) begin
      if (!rst_i && core_trigger_o) begin
         if (trig_exp.size() == 0) chk("unexpected_pulse", {56'd0, core_inputs_o}, 64'hFFFF);
         else chk("pulse_inputs", {56'd0, core_inputs_o}, {56'd0, trig_exp.pop_front()});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic map_out(input int io, input int slot, input logic en, input logic bc,
                          input logic [3:0] r, input logic [3:0] c);
      map_io_i = 3'(io); map_input_i = 1'b0; map_slot_i = 2'(slot);
      map_enable_i = en; map_broadcast_i = bc;
      map_remote_row_i = r; map_remote_col_i = c; map_valid_i = 1'b1;
      step();
      map_valid_i = 1'b0;
   endtask

   task automatic map_in(input int io, input logic [3:0] r, input logic [3:0] c,
                         input logic [2:0] idx, input logic seq);
      map_io_i = 3'(io); map_input_i = 1'b1; map_remote_row_i = r; map_remote_col_i = c;
      map_remote_idx_i = idx; map_seq_i = seq; map_valid_i = 1'b1;
      step();
      map_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      logic done;
      done = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 300 && !done; i++) begin
         if (idle_o && msg_exp.size() == 0 && trig_exp.size() == 0) done = 1'b1;
         else step();
      end
      chk(nm, {63'd0, done}, 64'd1);
   endtask

   initial begin
      logic seen;
      rst_i = 1'b1; node_row_i = 4'd1; node_col_i = 4'd1; trigger_i = 1'b0;
      msg_ready_i = 1'b1; map_io_i = '0; map_input_i = 1'b0; map_remote_row_i = '0;
      map_remote_col_i = '0; map_remote_idx_i = '0; map_slot_i = '0; map_enable_i = 1'b0;
      map_broadcast_i = 1'b0; map_seq_i = 1'b0; map_valid_i = 1'b0;
      signal_remote_row_i = '0; signal_remote_col_i = '0; signal_remote_idx_i = '0;
      signal_state_i = 1'b0; signal_valid_i = 1'b0; core_outputs_i = '0;
      repeat (3) step();
      chk("rst_valid", {63'd0, msg_valid_o}, 64'd0);
      chk("rst_data", {30'd0, msg_dir_o, msg_data_o}, 64'd0);
      chk("rst_core", {55'd0, core_trigger_o, core_inputs_o}, 64'd0);
      chk("rst_idle", {63'd0, idle_o}, 64'd1);
      rst_i = 1'b0;
      step();

      // single message east
      map_out(2, 0, 1'b1, 1'b0, 4'd1, 4'd3);
      push_msg(2'd1, mk(1'b0, 4'd1, 4'd3, 3'd2, 1'b1));
      core_outputs_i[2] = 1'b1;
      wait_idle("idle_after_single");

      // broadcast slot with stalled ready
      map_out(2, 1, 1'b1, 1'b1, 4'd5, 4'd5);
      msg_ready_i = 1'b0;
      push_msg(2'd1, mk(1'b0, 4'd1, 4'd3, 3'd2, 1'b0));
      for (int d = 0; d < 4; d++) push_msg(2'(d), mk(1'b1, 4'd5, 4'd5, 3'd2, 1'b0));
      core_outputs_i[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (msg_valid_o) seen = 1'b1;
         else step();
      end
      chk("stall_valid_seen", {63'd0, seen}, 64'd1);
      repeat (3) step();
      msg_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         msg_ready_i = (i % 3) != 0;
      end
      msg_ready_i = 1'b1;
      wait_idle("idle_after_bcast");
      chk("idle_bcast", {63'd0, idle_o}, 64'd1);

      // round-robin from pointer 3, routing W/S, own-node skip
      map_out(5, 0, 1'b1, 1'b0, 4'd1, 4'd3);
      map_out(5, 1, 1'b1, 1'b0, 4'd1, 4'd1);
      map_out(5, 2, 1'b1, 1'b0, 4'd1, 4'd0);
      map_out(5, 3, 1'b1, 1'b0, 4'd3, 4'd1);
      map_out(0, 0, 1'b1, 1'b0, 4'd0, 4'd1);
      push_msg(2'd1, mk(1'b0, 4'd1, 4'd3, 3'd5, 1'b1));
      push_msg(2'd3, mk(1'b0, 4'd1, 4'd0, 3'd5, 1'b1));
      push_msg(2'd2, mk(1'b0, 4'd3, 4'd1, 3'd5, 1'b1));
      push_msg(2'd0, mk(1'b0, 4'd0, 4'd1, 3'd0, 1'b1));
      core_outputs_i = core_outputs_i | 8'h21;
      wait_idle("idle_after_rr");

      // input capture: seq bit 4, non-seq bit 1, same key
      map_in(4, 4'd2, 4'd2, 3'd1, 1'b1);
      map_in(1, 4'd2, 4'd2, 3'd1, 1'b0);
      trig_exp.push_back(8'h02);
      signal_remote_row_i = 4'd2; signal_remote_col_i = 4'd2; signal_remote_idx_i = 3'd1;
      signal_state_i = 1'b1; signal_valid_i = 1'b1;
      step();
      signal_valid_i = 1'b0;
      repeat (3) step();
      chk("inputs_nonseq", {56'd0, core_inputs_o}, 64'h02);
      trig_exp.push_back(8'h12);
      trigger_i = 1'b1;
      step();
      trigger_i = 1'b0;
      repeat (3) step();
      chk("inputs_trigger", {56'd0, core_inputs_o}, 64'h12);

      // trigger and update on the same cycle: update wins for non-seq bit
      trig_exp.push_back(8'h10);
      signal_state_i = 1'b0; signal_valid_i = 1'b1; trigger_i = 1'b1;
      step();
      signal_valid_i = 1'b0; trigger_i = 1'b0;
      repeat (3) step();
      chk("inputs_collision", {56'd0, core_inputs_o}, 64'h10);
      trig_exp.push_back(8'h00);
      trigger_i = 1'b1;
      step();
      trigger_i = 1'b0;
      repeat (3) step();
      chk("inputs_seq_clear", {56'd0, core_inputs_o}, 64'h00);

      // own-node slot: loopback into input 0 or silently skipped
      map_in(0, 4'd1, 4'd1, 3'd3, 1'b0);
      map_out(3, 0, 1'b1, 1'b0, 4'd1, 4'd1);
`ifdef NX_NODE_LOOPBACK_EN
      trig_exp.push_back(8'h01);
`endif
      core_outputs_i[3] = 1'b1;
      wait_idle("idle_after_loopback");
`ifdef NX_NODE_LOOPBACK_EN
      chk("loopback_inputs", {56'd0, core_inputs_o}, 64'h01);
`else
      chk("loopback_inputs", {56'd0, core_inputs_o}, 64'h00);
`endif

      chk("msg_queue_empty", 64'(msg_exp.size()), 64'd0);
      chk("pulse_queue_empty", 64'(trig_exp.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
